// File: rtl/spi_z_pkg.sv
// Shared constants for the impedance-measurement SPI slave: frame codes and
// the FSM state type.
package spi_z_pkg;

    localparam logic [15:0] START_CODE = 16'hfedc;
    localparam logic [15:0] TEST_CODE  = 16'hff0a;
    localparam logic [15:0] STOP_CODE  = 16'h0123;

    typedef logic [1:0] z_state_t;

    localparam z_state_t ST_IDLE = 2'd0;
    localparam z_state_t ST_MEAS = 2'd1;
    localparam z_state_t ST_TEST = 2'd2;

endpackage

// File: rtl/spi_z_frontend.sv
// SPI mode-0 receive front end: 2-FF synchronisers on SCLK/CS_b/MOSI, edge
// detection, bit counter and MSB-first shift register. Emits the complete
// frame word with a one-clk strobe, and a one-clk error pulse when CS_b rises
// part-way through a frame.
module spi_z_frontend #(
    parameter int FRAME_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cs_b,
    input  logic                       i_sclk,
    input  logic                       i_mosi,
    output logic [FRAME_W-1:0]         o_word,
    output logic                       o_strobe,
    output logic                       o_err,
    output logic [$clog2(FRAME_W)-1:0] o_bit_cnt,
    output logic                       o_cs_low,
    output logic                       o_sclk_fall
);

    localparam int CNT_W = $clog2(FRAME_W);

    logic [1:0]         r_sclk_sync;
    logic [1:0]         r_cs_sync;
    logic [1:0]         r_mosi_sync;
    logic               r_sclk_d;
    logic               r_cs_d;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic               r_strobe;
    logic               r_err;

    logic w_sclk;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_low;
    logic w_cs_rise;
    logic w_mosi;

    assign w_sclk      = r_sclk_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_low    = ~r_cs_sync[1];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;

    // Synchronise the SPI pins into clk and keep one delayed copy for edges.
    // CS_b resets to its inactive (high) level so reset never looks like a
    // CS_b rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_sclk};
            r_cs_sync   <= {r_cs_sync[0], i_cs_b};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= r_cs_sync[1];
        end
    end

    // Count and shift bits on SCLK rising edges; strobe after the last bit,
    // flag and discard a frame cut short by CS_b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_strobe  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
            if (w_cs_rise) begin
                if (r_bit_cnt != '0) begin
                    r_err <= 1'b1;
                end
                r_bit_cnt <= '0;
            end else if (w_cs_low && w_sclk_rise) begin
                r_shift <= {r_shift[FRAME_W-2:0], w_mosi};
                if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
                    r_bit_cnt <= '0;
                    r_strobe  <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign o_word      = r_shift;
    assign o_strobe    = r_strobe;
    assign o_err       = r_err;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_cs_low    = w_cs_low;
    assign o_sclk_fall = w_sclk_fall;

endmodule

// File: rtl/spi_slave_zn.sv
// SPI slave controlling an impedance sweep over two electrode groups.
// Frames are {code, payload}; START/STOP/TEST codes drive the FSM, other
// codes in MEAS deliver stimulus words and advance the electrode sweep.
// Optional feature macro: SPI_Z_TEST_EN (TEST state and MISO readback of
// TEST_CODE). Without it MISO and miso_oe are tied low.
module spi_slave_zn
    import spi_z_pkg::*;
#(
    parameter int FRAME_W = 32,
    parameter int N_CH    = 16,
    parameter int SR_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CS_b,
    input  logic                   SCLK,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic                   miso_oe,
    output logic [N_CH-1:0]        ch_sel,
    output logic [FRAME_W/2-1:0]   d_out_a,
    output logic [FRAME_W/2-1:0]   d_out_b,
    output logic                   d_valid,
    output logic                   z_meas_en,
    output logic                   data_rdy_nsl,
    output logic                   meas_done,
    output logic                   frame_err,
    output logic [SR_W-1:0]        s_r,
    output logic [1:0]             o_dbg_state
);

    localparam int HALF  = FRAME_W / 2;
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [FRAME_W-1:0] w_word;
    logic               w_strobe;
    logic               w_fe_err;
    logic [CNT_W-1:0]   w_bit_cnt;
    logic               w_cs_low;
    logic               w_sclk_fall;
    logic [HALF-1:0]    w_code;
    logic [HALF-1:0]    w_payload;
    logic [HALF-1:0]    w_stim_next;

    z_state_t           r_state;
    logic [HALF-1:0]    r_cycles;
    logic [HALF-1:0]    r_stim_n;
    logic [CH_W-1:0]    r_ch;
    logic               r_first_seen;

    spi_z_frontend #(
        .FRAME_W (FRAME_W)
    ) u_frontend (
        .clk         (clk),
        .rst         (rst),
        .i_cs_b      (CS_b),
        .i_sclk      (SCLK),
        .i_mosi      (MOSI),
        .o_word      (w_word),
        .o_strobe    (w_strobe),
        .o_err       (w_fe_err),
        .o_bit_cnt   (w_bit_cnt),
        .o_cs_low    (w_cs_low),
        .o_sclk_fall (w_sclk_fall)
    );

    assign w_code      = w_word[FRAME_W-1:HALF];
    assign w_payload   = w_word[HALF-1:0];
    assign w_stim_next = r_stim_n + HALF'(1);

    // Frame decode, FSM and sweep counters. A control code always wins over
    // data handling, so a START/STOP landing on the last sweep frame acts as
    // control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cycles     <= '0;
            r_stim_n     <= '0;
            r_ch         <= '0;
            r_first_seen <= 1'b0;
            d_out_a      <= '0;
            d_out_b      <= '0;
            d_valid      <= 1'b0;
            data_rdy_nsl <= 1'b0;
            meas_done    <= 1'b0;
            frame_err    <= 1'b0;
            s_r          <= '0;
        end else begin
            d_valid   <= 1'b0;
            meas_done <= 1'b0;
            frame_err <= w_fe_err;
            if (w_strobe) begin
                if (w_code == HALF'(STOP_CODE)) begin
                    r_state      <= ST_IDLE;
                    s_r          <= w_payload[SR_W-1:0];
                    r_cycles     <= '0;
                    r_stim_n     <= '0;
                    r_ch         <= '0;
                    r_first_seen <= 1'b0;
                    data_rdy_nsl <= 1'b0;
                end else if (w_code == HALF'(START_CODE)) begin
                    if (w_payload != '0) begin
                        r_state      <= ST_MEAS;
                        r_cycles     <= w_payload;
                        r_stim_n     <= '0;
                        r_ch         <= '0;
                        r_first_seen <= 1'b0;
                        data_rdy_nsl <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                    end
`ifdef SPI_Z_TEST_EN
                end else if (w_code == HALF'(TEST_CODE)) begin
                    r_state      <= ST_TEST;
                    r_cycles     <= '0;
                    r_stim_n     <= '0;
                    r_ch         <= '0;
                    r_first_seen <= 1'b0;
                    data_rdy_nsl <= 1'b0;
`endif
                end else if (r_state == ST_MEAS) begin
                    d_out_a      <= w_code;
                    d_out_b      <= w_payload;
                    d_valid      <= 1'b1;
                    r_first_seen <= 1'b1;
                    if (r_first_seen) begin
                        data_rdy_nsl <= 1'b1;
                    end
                    if (w_stim_next == r_cycles) begin
                        r_stim_n <= '0;
                        if (r_ch == CH_W'(N_CH - 1)) begin
                            r_state      <= ST_IDLE;
                            meas_done    <= 1'b1;
                            r_ch         <= '0;
                            r_first_seen <= 1'b0;
                            data_rdy_nsl <= 1'b0;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end else begin
                        r_stim_n <= w_stim_next;
                    end
                end
            end
        end
    end

    assign ch_sel      = (r_state == ST_MEAS) ? (N_CH'(1) << r_ch) : '0;
    assign z_meas_en   = (r_state == ST_MEAS);
    assign o_dbg_state = r_state;

`ifdef SPI_Z_TEST_EN
    logic [HALF-1:0] r_tx;
    logic            w_oe;

    assign w_oe = (r_state == ST_TEST) && w_cs_low;

    // TEST readback: MSB of TEST_CODE is preloaded while CS_b is high, then
    // the code shifts out on SCLK falls and reloads at each half-frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx <= '0;
        end else if (!w_cs_low) begin
            r_tx <= HALF'(TEST_CODE);
        end else if (w_sclk_fall) begin
            if (w_bit_cnt == '0 || w_bit_cnt == CNT_W'(HALF)) begin
                r_tx <= HALF'(TEST_CODE);
            end else begin
                r_tx <= {r_tx[HALF-2:0], 1'b0};
            end
        end
    end

    assign miso_oe = w_oe;
    assign MISO    = w_oe & r_tx[HALF-1];
`else
    logic w_unused_tx;

    assign w_unused_tx = &{1'b0, w_sclk_fall, w_bit_cnt, w_cs_low};
    assign miso_oe     = 1'b0;
    assign MISO        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_zn.sv
// Bench for spi_slave_zn with default parameters: directed vector table,
// hand-written reset/sweep/readback sequences, then random frames checked
// against a frame-level model of the sweep.
module tb_spi_slave_zn;

    localparam int N_CH = 16;
    localparam int HP   = 5;  // clk cycles per SCLK half period

    logic        clk;
    logic        rst;
    logic        CS_b;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        miso_oe;
    logic [15:0] ch_sel;
    logic [15:0] d_out_a;
    logic [15:0] d_out_b;
    logic        d_valid;
    logic        z_meas_en;
    logic        data_rdy_nsl;
    logic        meas_done;
    logic        frame_err;
    logic [4:0]  s_r;
    logic [1:0]  o_dbg_state;

    spi_slave_zn dut (
        .clk          (clk),
        .rst          (rst),
        .CS_b         (CS_b),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .miso_oe      (miso_oe),
        .ch_sel       (ch_sel),
        .d_out_a      (d_out_a),
        .d_out_b      (d_out_b),
        .d_valid      (d_valid),
        .z_meas_en    (z_meas_en),
        .data_rdy_nsl (data_rdy_nsl),
        .meas_done    (meas_done),
        .frame_err    (frame_err),
        .s_r          (s_r),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard
    logic [31:0] exp_q[$];
    int dv_cnt = 0;
    int fe_cnt = 0;
    int md_cnt = 0;
    int md_total = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (d_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL d_valid_unexpected actual=%h required=none", {d_out_a, d_out_b});
                end else begin
                    chk("d_out", {d_out_a, d_out_b}, exp_q.pop_front());
                end
            end
            if (frame_err) fe_cnt++;
            if (meas_done) begin
                md_cnt++;
                md_total++;
                chk("meas_done_with_d_valid", {31'd0, d_valid}, 32'd1);
            end
        end
    end

    // driver
    task automatic send_frame(input logic [31:0] w, input int nbits,
                              output logic [31:0] rx, output logic oe_seen);
        rx = '0;
        oe_seen = 1'b0;
        CS_b = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[31-i];
            repeat (HP) @(posedge clk);
            #1;
            rx = {rx[30:0], MISO};
            oe_seen = oe_seen | miso_oe;
            SCLK = 1'b1;
            repeat (HP) @(posedge clk);
            #1;
            SCLK = 1'b0;
        end
        repeat (HP) @(posedge clk);
        #1;
        CS_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // reference model: mode 0 idle, 1 meas, 2 test; k = data frames since START
    int          m_mode = 0;
    int          m_cyc  = 1;
    int          m_k    = 0;
    logic        m_rdy  = 1'b0;
    logic [4:0]  m_sr   = '0;

    task automatic run_frame(input logic [31:0] w, input int nbits, output logic [31:0] rx);
        int e_dv = 0;
        int e_fe = 0;
        int e_md = 0;
        logic e_oe;
        logic oe;
        logic [15:0] code;
        logic [15:0] p;
        code = w[31:16];
        p    = w[15:0];
`ifdef SPI_Z_TEST_EN
        e_oe = (m_mode == 2);
`else
        e_oe = 1'b0;
`endif
        if (nbits < 32) begin
            e_fe = 1;
        end else if (code == 16'h0123) begin
            m_mode = 0; m_sr = p[4:0]; m_rdy = 1'b0;
        end else if (code == 16'hfedc) begin
            if (p == 16'd0) e_fe = 1;
            else begin m_mode = 1; m_cyc = int'(p); m_k = 0; m_rdy = 1'b0; end
`ifdef SPI_Z_TEST_EN
        end else if (code == 16'hff0a) begin
            m_mode = 2; m_rdy = 1'b0;
`endif
        end else if (m_mode == 1) begin
            e_dv = 1;
            exp_q.push_back(w);
            m_k++;
            if (m_k >= 2) m_rdy = 1'b1;
            if (m_k == m_cyc * N_CH) begin
                e_md = 1; m_mode = 0; m_rdy = 1'b0;
            end
        end
        dv_cnt = 0; fe_cnt = 0; md_cnt = 0;
        send_frame(w, nbits, rx, oe);
        chk("d_valid_count", dv_cnt, e_dv);
        chk("frame_err_count", fe_cnt, e_fe);
        chk("meas_done_count", md_cnt, e_md);
        chk("z_meas_en", {31'd0, z_meas_en}, {31'd0, (m_mode == 1)});
        chk("ch_sel", {16'd0, ch_sel}, (m_mode == 1) ? (32'd1 << (m_k / m_cyc)) : 32'd0);
        chk("data_rdy_nsl", {31'd0, data_rdy_nsl}, {31'd0, m_rdy});
        chk("s_r", {27'd0, s_r}, {27'd0, m_sr});
        chk("miso_oe_seen", {31'd0, oe}, {31'd0, e_oe});
    endtask

    // directed vector table
    typedef struct {
        logic [31:0] w;
        int          nbits;
        int          e_dv;
        int          e_fe;
        logic        e_zen;
        logic [15:0] e_chsel;
        logic        e_rdy;
        logic [4:0]  e_sr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] rx;
        logic        oe;
        logic [31:0] w;
        int          r;

        tbl[0] = '{32'hfedc_0000, 32, 0, 1, 1'b0, 16'h0000, 1'b0, 5'h00};
        tbl[1] = '{32'hfedc_0001, 32, 0, 0, 1'b1, 16'h0001, 1'b0, 5'h00};
        tbl[2] = '{32'h1234_5678, 32, 1, 0, 1'b1, 16'h0002, 1'b0, 5'h00};
        tbl[3] = '{32'habcd_0000, 17, 0, 1, 1'b1, 16'h0002, 1'b0, 5'h00};
        tbl[4] = '{32'haaaa_5555, 32, 1, 0, 1'b1, 16'h0004, 1'b1, 5'h00};
        tbl[5] = '{32'h0123_0015, 32, 0, 0, 1'b0, 16'h0000, 1'b0, 5'h15};
        tbl[6] = '{32'h1111_2222, 32, 0, 0, 1'b0, 16'h0000, 1'b0, 5'h15};
        tbl[7] = '{32'hfedc_0002, 32, 0, 0, 1'b1, 16'h0001, 1'b0, 5'h15};
        tbl[8] = '{32'h0000_ffff, 32, 1, 0, 1'b1, 16'h0001, 1'b0, 5'h15};
        tbl[9] = '{32'h0123_0007, 32, 0, 0, 1'b0, 16'h0000, 1'b0, 5'h07};

        rst = 1'b1; CS_b = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_MISO", {31'd0, MISO}, 32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_ch_sel", {16'd0, ch_sel}, 32'd0);
        chk("rst_d_out", {d_out_a, d_out_b}, 32'd0);
        chk("rst_flags", {27'd0, d_valid, z_meas_en, data_rdy_nsl, meas_done, frame_err}, 32'd0);
        chk("rst_s_r", {27'd0, s_r}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].e_dv != 0) exp_q.push_back(tbl[i].w);
            dv_cnt = 0; fe_cnt = 0;
            send_frame(tbl[i].w, tbl[i].nbits, rx, oe);
            chk($sformatf("tbl%0d_d_valid", i), dv_cnt, tbl[i].e_dv);
            chk($sformatf("tbl%0d_frame_err", i), fe_cnt, tbl[i].e_fe);
            chk($sformatf("tbl%0d_z_meas_en", i), {31'd0, z_meas_en}, {31'd0, tbl[i].e_zen});
            chk($sformatf("tbl%0d_ch_sel", i), {16'd0, ch_sel}, {16'd0, tbl[i].e_chsel});
            chk($sformatf("tbl%0d_data_rdy", i), {31'd0, data_rdy_nsl}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_s_r", i), {27'd0, s_r}, {27'd0, tbl[i].e_sr});
        end
        chk("tbl_dout_last", {d_out_a, d_out_b}, 32'h0000_ffff);
        chk("tbl_queue_drained", exp_q.size(), 32'd0);
        m_mode = 0; m_sr = 5'h07; m_rdy = 1'b0;

        // reset in the middle of a frame while measuring
        run_frame(32'hfedc_0003, 32, rx);
        fe_cnt = 0;
        CS_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            repeat (HP) @(posedge clk);
            #1 SCLK = 1'b1;
            repeat (HP) @(posedge clk);
            #1 SCLK = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 CS_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_z_meas_en", {31'd0, z_meas_en}, 32'd0);
        chk("midrst_s_r", {27'd0, s_r}, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_frame_err", fe_cnt, 32'd0);
        m_mode = 0; m_sr = '0; m_rdy = 1'b0;

        // full sweep: 2 frames per electrode, 16 electrodes
        md_total = 0;
        run_frame(32'hfedc_0002, 32, rx);
        for (int i = 0; i < 32; i++) begin
            run_frame({16'h4000 + 16'(i), 16'($urandom)}, 32, rx);
        end
        chk("sweep_meas_done_total", md_total, 32'd1);

        // STOP in the middle of a sweep
        run_frame(32'hfedc_0001, 32, rx);
        run_frame(32'h5555_0001, 32, rx);
        run_frame(32'h5555_0002, 32, rx);
        run_frame(32'h0123_0015, 32, rx);

        // TEST readback
        run_frame(32'hff0a_0000, 32, rx);
        run_frame(32'h0000_0000, 32, rx);
`ifdef SPI_Z_TEST_EN
        chk("test_readback", rx, 32'hff0a_ff0a);
`else
        chk("test_readback_off", rx, 32'h0000_0000);
`endif
        run_frame(32'h0123_0000, 32, rx);

        // random frames against the model
        run_frame(32'hfedc_0001, 32, rx);
        for (int i = 0; i < 50; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                run_frame({16'h0123, 16'($urandom)}, 32, rx);
            end else if (r < 14) begin
                run_frame({16'hfedc, 16'($urandom_range(0, 2))}, 32, rx);
            end else if (r < 18) begin
                run_frame({16'hff0a, 16'($urandom)}, 32, rx);
            end else if (r < 24) begin
                run_frame($urandom, int'($urandom_range(1, 31)), rx);
            end else begin
                w = $urandom;
                if (w[31:16] == 16'hfedc || w[31:16] == 16'hff0a || w[31:16] == 16'h0123)
                    w[16] = ~w[16];
                run_frame(w, 32, rx);
            end
        end
        chk("final_queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_zn.md
SPI_SLAVE_ZN -- requirements
Module: spi_slave_zn

Interface
REQ-001 Parameter FRAME_W, default 32, SPI frame length in bits; even, >=16; high half = code, low half = payload.
REQ-002 Parameter N_CH, default 16, electrodes per group; two groups (a, b) are measured concurrently.
REQ-003 Parameter SR_W, default 5, width of the stop-frame config field.
REQ-004 clk  in  1  system clock; frequency >= 4x SCLK.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 CS_b  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 SCLK  in  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 MOSI  in  1  SPI data in, MSB first.
REQ-009 MISO  out  1  SPI data out; miso_oe  out  1  MISO drive enable.
REQ-010 ch_sel  out  N_CH  one-hot active electrode index.
REQ-011 d_out_a, d_out_b  out  FRAME_W/2 each  latest stimulus word for group a/b.
REQ-012 d_valid  out  1  one-clk pulse when d_out_a/b update.
REQ-013 z_meas_en  out  1  measurement active; data_rdy_nsl  out  1  feedback data valid.
REQ-014 meas_done  out  1  one-clk pulse at sweep end; frame_err  out  1  one-clk pulse on bad frame.
REQ-015 s_r  out  SR_W  config latched from stop frame.

Function
REQ-016 SCLK, CS_b, MOSI SHALL pass 2-FF synchronisers; MOSI sampled on synced SCLK rising edge while CS_b low; MISO updated on synced SCLK falling edge.
REQ-017 Bit counter SHALL count 0..FRAME_W-1; on the FRAME_W-th sample the frame is decoded on the next clk (latency 1 clk after edge detect).
REQ-018 CS_b rising with bit counter 1..FRAME_W-1: frame discarded, counter cleared, frame_err pulsed, no state change.
REQ-019 FSM states: IDLE, MEAS, TEST; decode on code = high half.
REQ-020 START_CODE: payload nonzero -> cycles <= payload, stim_n <= 0, ch <= 0, MEAS; payload zero -> frame_err, state unchanged.
REQ-021 STOP_CODE from any state -> IDLE; s_r <= payload[SR_W-1:0]; cycles, stim_n, ch cleared.
REQ-022 TEST_CODE from any state -> TEST; measurement counters cleared.
REQ-023 Other codes in MEAS: d_out_a <= high half, d_out_b <= low half, d_valid pulse, stim_n++; in IDLE/TEST ignored, no pulse.
REQ-024 Each electrode SHALL receive exactly cycles data frames: when stim_n reaches cycles, ch++ and stim_n <= 0; when ch = N_CH-1, -> IDLE with meas_done pulse coincident with the last d_valid.
REQ-025 ch_sel = 1<<ch in MEAS, all-zero otherwise; z_meas_en = (state==MEAS).
REQ-026 data_rdy_nsl SHALL set on the second d_valid after START and clear on leaving MEAS.
REQ-027 stim_n and cycles SHALL be FRAME_W/2 bits; ch SHALL be $clog2(N_CH) bits; no wrap beyond N_CH-1.
REQ-028 Decode and a START/STOP arriving on the final data frame: the frame's own code wins; final-frame data is still output.

Reset
REQ-029 rst SHALL force IDLE; all outputs 0 except MISO 0, miso_oe 0; shift register, counters, s_r cleared.
REQ-030 rst mid-frame SHALL discard the partial frame without frame_err.

Configuration
REQ-031 SPI_Z_TEST_EN defined: in TEST with CS_b low, miso_oe=1 and MISO shifts TEST_CODE MSB-first, reloaded at bit 0 and bit FRAME_W/2.
REQ-032 SPI_Z_TEST_EN undefined: TEST_CODE treated as an unknown code, TEST state absent, miso_oe and MISO tied 0.

Structure
REQ-033 Package spi_z_pkg SHALL hold START_CODE 16'hfedc, TEST_CODE 16'hff0a, STOP_CODE 16'h0123 and the state type.
REQ-034 Sub-module spi_z_frontend SHALL contain synchronisers, edge detect, bit counter and shift register, emitting frame word + frame_strobe + frame_err.

Verification
REQ-035 START payload 2, N_CH=16, 32 data frames -> 32 d_valid, ch_sel 0x0001 for frames 1-2, 0x8000 for 31-32, meas_done with frame 32.
REQ-036 Data frame 0x1234_5678 in MEAS -> d_out_a=0x1234, d_out_b=0x5678, d_valid one clk.
REQ-037 CS_b raised after 17 bits -> frame_err pulse, d_valid absent, state unchanged.
REQ-038 STOP payload 0x0015 mid-sweep -> IDLE, ch_sel 0, s_r=5'h15, data_rdy_nsl 0.
REQ-039 TEST frame then 32-bit read (macro defined) -> MISO returns 0xff0a_ff0a; macro undefined -> miso_oe stays 0.
REQ-040 START payload 0 -> frame_err, z_meas_en stays 0.
